// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game controller.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package reaction_pkg;

   localparam int          VALUE_W   = 14;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_POLY = 16'hB400;

   // Game states, 3-bit encoding kept stable for existing debug tooling
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WAIT  = 3'd1;
   localparam logic [2:0] ST_GO    = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;
   localparam logic [2:0] ST_ERROR = 3'd4;

   // One step of the right-shifting Galois LFSR; a non-zero state never maps to zero
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
   endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Push-button conditioning: 2-FF synchronizer followed by a registered rising-edge detector.
// Latency: press pulses for one cycle, 3 clk edges after btn rises.
// Backpressure: none; a button held high yields exactly one press pulse.
module btn_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   logic sync_q1;
   logic sync_q2;
   logic sync_q3;

   // Resynchronize the raw button and register a pulse on its first high sample
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         sync_q3 <= 1'b0;
         press   <= 1'b0;
      end else begin
         sync_q1 <= btn;
         sync_q2 <= sync_q1;
         sync_q3 <= sync_q2;
         press   <= sync_q2 & ~sync_q3;
      end
   end

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time game controller: random pre-delay, GO LED, then ms count until the player presses.
// Latency: state and all outputs update on the clock edge after the press/tick cycle (all registered).
// Backpressure: none; presses are single pulses and are acted on in the cycle they arrive.
module reaction_timer
   import reaction_pkg::*;
#(
   parameter int CLKS_PER_MS  = 10000,
   parameter int MIN_DELAY_MS = 1000,
   parameter int RAND_BITS    = 11,
   parameter int MAX_MS       = 9999
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               btn,
   output logic [VALUE_W-1:0] value,
   output logic               show_error,
   output logic               go_led,
   output logic               busy
);

   localparam int DLY_RAW = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));
   localparam int DLY_W   = (DLY_RAW > 1) ? DLY_RAW : 1;
   localparam int PS_RAW  = $clog2(CLKS_PER_MS);
   localparam int PS_W    = (PS_RAW > 1) ? PS_RAW : 1;

   localparam logic [PS_W-1:0]    PS_LAST     = PS_W'(CLKS_PER_MS - 1);
   localparam logic [DLY_W-1:0]   DLY_BASE    = DLY_W'(MIN_DELAY_MS);
   localparam logic [DLY_W-1:0]   DLY_ONE     = DLY_W'(1);
   localparam logic [VALUE_W-1:0] VAL_ONE     = VALUE_W'(1);
   localparam logic [VALUE_W-1:0] VAL_PRE_MAX = VALUE_W'(MAX_MS - 1);

   logic             press;
   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [15:0]      lfsr;
   logic [PS_W-1:0]  presc;
   logic             tick;
   logic [DLY_W-1:0] delay_cnt;
   logic             load_delay;

   btn_sync_edge u_btn (
      .clk   (clk),
      .reset (reset),
      .btn   (btn),
      .press (press)
   );

   assign tick       = (presc == PS_LAST);
   assign load_delay = press && ((state == ST_IDLE) || (state == ST_DONE));

   // Next-state decode; a press always beats a coincident tick
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (press) state_nxt = ST_WAIT;
         ST_WAIT:  if (press) state_nxt = ST_ERROR;
                   else if (tick && (delay_cnt == DLY_ONE)) state_nxt = ST_GO;
         ST_GO:    if (press) state_nxt = ST_DONE;
                   else if (tick && (value == VAL_PRE_MAX)) state_nxt = ST_DONE;
         ST_DONE:  if (press) state_nxt = ST_WAIT;
         ST_ERROR: if (press) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State register plus status outputs registered from the next state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         go_led     <= 1'b0;
         busy       <= 1'b0;
         show_error <= 1'b0;
      end else begin
         state      <= state_nxt;
         go_led     <= (state_nxt == ST_GO);
         busy       <= (state_nxt == ST_WAIT) || (state_nxt == ST_GO);
         show_error <= (state_nxt == ST_ERROR);
      end
   end

   // Free-running LFSR, stepped every cycle regardless of state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr <= LFSR_SEED;
      else       lfsr <= lfsr_next(lfsr);
   end

   // ms prescaler; restarting on each state change makes the first tick a full ms later
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                              presc <= '0;
      else if ((state_nxt != state) || tick)  presc <= '0;
      else                                    presc <= presc + PS_W'(1);
   end

   // Pre-delay countdown: loaded on round start, decremented on each WAIT tick
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                              delay_cnt <= '0;
      else if (load_delay)                    delay_cnt <= DLY_BASE + DLY_W'(lfsr[RAND_BITS-1:0]);
      else if ((state == ST_WAIT) && tick)    delay_cnt <= delay_cnt - DLY_ONE;
   end

   // Reaction count: cleared entering GO or ERROR, counts GO ticks unless a press arrives
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value <= '0;
      end else if ((state == ST_WAIT) && (state_nxt != ST_WAIT)) begin
         value <= '0;
      end else if ((state == ST_GO) && !press && tick) begin
         value <= value + VAL_ONE;
      end
   end

endmodule

// File: tb/tb_reaction_timer.sv
module tb_reaction_timer;

   localparam int CPM  = 4;
   localparam int MIND = 2;
   localparam int RB   = 2;
   localparam int MAXV = 12;

   logic        clk = 1'b0;
   logic        reset;
   logic        btn;
   logic [13:0] value;
   logic        show_error;
   logic        go_led;
   logic        busy;

   reaction_timer #(
      .CLKS_PER_MS  (CPM),
      .MIN_DELAY_MS (MIND),
      .RAND_BITS    (RB),
      .MAX_MS       (MAXV)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .btn        (btn),
      .value      (value),
      .show_error (show_error),
      .go_led     (go_led),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] m_lfsr;
   logic [15:0] lfsr_before;
   logic        busy_q;
   logic        go_q;
   bit          tracking;
   int          wcnt;
   int          exp_delay;
   int          press_cnt;
   int          r;
   int          exp_v;

   // Reference LFSR step: shift right, fold taps 0xB400 in when a one falls out
   function automatic logic [15:0] ref_lfsr_step(input logic [15:0] s);
      logic [15:0] n;
      n = s >> 1;
      if (s[0]) n = n ^ 16'hB400;
      return n;
   endfunction

   // Reaction value for a press acted on n cycles after GO started (tick on that edge does not count)
   function automatic int exp_go_value(input int n);
      int v;
      v = (n - 1) / CPM;
      return (v > MAXV) ? MAXV : v;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one cycle, sample #1 after the edge, and run the per-cycle monitors
   task automatic step();
      lfsr_before = m_lfsr;
      @(posedge clk);
      if (reset) m_lfsr = 16'hACE1;
      else       m_lfsr = ref_lfsr_step(m_lfsr);
      #1;
      check("lfsr_model", 32'(dut.lfsr), 32'(m_lfsr));
      check("lfsr_nonzero", 32'(dut.lfsr != 16'h0000), 32'd1);
      if (dut.press === 1'b1) press_cnt++;
      if (tracking) wcnt++;
      if (busy && !busy_q && !go_led) begin
         tracking  = 1'b1;
         wcnt      = 0;
         exp_delay = CPM * (MIND + int'(lfsr_before[RB-1:0]));
      end
      if (go_led && !go_q && tracking) begin
         check("pre_delay", 32'(wcnt), 32'(exp_delay));
         check("pre_delay_range", 32'((wcnt >= 8) && (wcnt <= 20)), 32'd1);
         tracking = 1'b0;
      end
      if (!busy) tracking = 1'b0;
      busy_q = busy;
      go_q   = go_led;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Raise btn for 4 cycles; returns right after the edge where the press is acted on
   task automatic push();
      btn = 1'b1;
      idle(4);
      btn = 1'b0;
   endtask

   task automatic wait_go();
      for (int i = 0; i < 40 && !go_led; i++) step();
      check("go_seen", 32'(go_led), 32'd1);
   endtask

   initial begin
      reset     = 1'b1;
      btn       = 1'b0;
      m_lfsr    = 16'hACE1;
      busy_q    = 1'b0;
      go_q      = 1'b0;
      tracking  = 1'b0;
      wcnt      = 0;
      exp_delay = 0;
      press_cnt = 0;

      // Reset, then idle
      idle(3);
      reset = 1'b0;
      idle(50);
      check("idle_value", 32'(value), 32'd0);
      check("idle_show_error", 32'(show_error), 32'd0);
      check("idle_go_led", 32'(go_led), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);

      // Normal round; the second press lands on a GO tick edge (n=32) and must not count it
      push();
      check("round_busy", 32'(busy), 32'd1);
      check("round_go_low", 32'(go_led), 32'd0);
      wait_go();
      idle(28);
      push();
      check("round_value", 32'(value), 32'd7);
      check("round_go_off", 32'(go_led), 32'd0);
      check("round_busy_off", 32'(busy), 32'd0);
      for (int i = 0; i < 100; i++) begin
         step();
         check("round_value_hold", 32'(value), 32'd7);
      end

      // False start
      push();
      check("fs_busy", 32'(busy), 32'd1);
      idle(1);
      push();
      check("fs_show_error", 32'(show_error), 32'd1);
      check("fs_value", 32'(value), 32'd0);
      check("fs_go_led", 32'(go_led), 32'd0);
      check("fs_busy_off", 32'(busy), 32'd0);
      idle(2);
      push();
      check("fs_clear", 32'(show_error), 32'd0);
      check("fs_idle_busy", 32'(busy), 32'd0);
      idle(2);

      // Held button: one press only, so the round times out instead of going to ERROR
      press_cnt = 0;
      btn = 1'b1;
      idle(200);
      btn = 1'b0;
      check("held_press_count", 32'(press_cnt), 32'd1);
      check("held_show_error", 32'(show_error), 32'd0);
      check("held_value", 32'(value), 32'(MAXV));
      check("held_busy", 32'(busy), 32'd0);
      idle(3);

      // Timeout: enter GO and never press
      push();
      wait_go();
      for (int n = 1; n <= 60; n++) begin
         step();
         exp_v = (n / CPM > MAXV) ? MAXV : n / CPM;
         check("to_value", 32'(value), 32'(exp_v));
         check("to_go_led", 32'(go_led), 32'(n < CPM * MAXV));
         check("to_busy", 32'(busy), 32'(n < CPM * MAXV));
      end
      idle(2);

      // Press acted on the same edge as the final WAIT tick
      push();
      check("exp_busy", 32'(busy), 32'd1);
      idle(exp_delay - 4);
      push();
      check("exp_show_error", 32'(show_error), 32'd1);
      check("exp_go_led", 32'(go_led), 32'd0);
      check("exp_busy_off", 32'(busy), 32'd0);
      check("exp_value", 32'(value), 32'd0);
      idle(2);
      push();
      check("exp_clear", 32'(show_error), 32'd0);

      // Randomized rounds checked against the reaction-value model
      for (int k = 0; k < 6; k++) begin
         idle(2);
         push();
         wait_go();
         r = int'($urandom_range(0, 40));
         idle(r);
         push();
         check("rnd_value", 32'(value), 32'(exp_go_value(r + 4)));
         check("rnd_go_led", 32'(go_led), 32'd0);
         check("rnd_busy", 32'(busy), 32'd0);
      end

      // Reset in the middle of GO
      idle(2);
      push();
      wait_go();
      for (int i = 0; i < 30 && value != 14'd3; i++) step();
      check("mid_value_pre", 32'(value), 32'd3);
      reset = 1'b1;
      #1;
      check("rst_value", 32'(value), 32'd0);
      check("rst_go_led", 32'(go_led), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      m_lfsr   = 16'hACE1;
      tracking = 1'b0;
      busy_q   = 1'b0;
      go_q     = 1'b0;
      idle(2);
      reset = 1'b0;
      idle(2);
      push();
      check("post_rst_busy", 32'(busy), 32'd1);
      check("post_rst_go_led", 32'(go_led), 32'd0);
      check("post_rst_value", 32'(value), 32'd0);
      check("post_rst_show_error", 32'(show_error), 32'd0);
      wait_go();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Game controller for the reaction-time test. Sits directly upstream of the seven-segment display driver.
- Runs a random pre-delay, then lights the GO LED and counts elapsed milliseconds until the player presses.
- Drives the display driver's 14-bit value input (0..9999 ms) and its show_error flag; show_error is raised on a false start.

Parameters:
- CLKS_PER_MS, 10000, clock cycles per millisecond tick (10 MHz clock).
- MIN_DELAY_MS, 1000, fixed part of the random pre-delay, in ms.
- RAND_BITS, 11, width of the random part of the pre-delay (adds 0..2^RAND_BITS-1 ms).
- MAX_MS, 9999, saturation/timeout value of the reaction count.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- btn  input  1  raw player push-button, active-high, asynchronous to clk
- value  output  14  reaction time in ms, to display driver value input
- show_error  output  1  false-start flag, to display driver show_error input
- go_led  output  1  stimulus LED, high while the player should press
- busy  output  1  high in WAIT or GO (round in progress)

Behaviour:
- Reset, asynchronous, all outputs registered: value=0, show_error=0, go_led=0, busy=0, state=IDLE, prescaler=0, LFSR=16'hACE1.
- Button input path:
  - 2-FF synchronizer, then rising-edge detector.
  - Produces a 1-cycle press pulse 3 cycles after btn rises.
  - A held button yields only one press.
- LFSR:
  - 16-bit Galois, polynomial 0xB400, shifts every cycle in every state.
  - Never zero.
- ms prescaler:
  - Counts 0..CLKS_PER_MS-1; tick is asserted when it equals CLKS_PER_MS-1.
  - Cleared on every state transition, so the first tick after entering a state comes exactly CLKS_PER_MS cycles later.
- IDLE:
  - go_led=0, show_error=0.
  - press -> WAIT; delay_cnt loads MIN_DELAY_MS + LFSR[RAND_BITS-1:0].
- WAIT:
  - busy=1, go_led=0; value holds its previous value.
  - Each tick decrements delay_cnt.
  - press -> ERROR (press wins over simultaneous expiry).
  - tick with delay_cnt==1 -> GO: value cleared to 0, go_led=1 from the next cycle.
- GO:
  - busy=1, go_led=1.
  - Each tick increments value.
  - press -> DONE with value frozen; a press coinciding with a tick does not increment.
  - tick with value==MAX_MS-1 -> value=MAX_MS, DONE (timeout). value never exceeds MAX_MS.
- DONE:
  - go_led=0, busy=0, value held for display.
  - press -> WAIT with a new random delay.
- ERROR:
  - show_error=1, go_led=0, busy=0, value=0.
  - press -> IDLE, show_error cleared.
- State and output timing:
  - State changes take effect on the clock edge after the press/tick cycle.
  - Outputs change on that same edge; no combinational output paths.
- Reset asserted mid-round: immediate return to reset values; go_led drops asynchronously.
- Widths and counter range:
  - delay_cnt width = max(clog2(MIN_DELAY_MS + 2^RAND_BITS), 1).
  - value arithmetic is 14-bit unsigned.
  - The prescaler never wraps outside 0..CLKS_PER_MS-1.

Decomposition:
- Shared package reaction_pkg:
  - state enum: IDLE, WAIT, GO, DONE, ERROR (3-bit encoding).
  - VALUE_W=14, LFSR_SEED=16'hACE1, LFSR_POLY=16'hB400.
- Sub-module btn_sync_edge: 2-FF synchronizer plus rising-edge pulse, with clk/reset. The display driver keeps its own logic.
- FSM, prescaler, LFSR and counters live in reaction_timer.

Test Plan (bench overrides CLKS_PER_MS=4, MIN_DELAY_MS=2, RAND_BITS=2):
- Reset then idle 50 cycles -> value=0, show_error=0, go_led=0, busy=0; LFSR never 0 (checked every cycle).
- Normal round:
  - Stimulus: press, wait for go_led rise, hold 28 cycles, press.
  - Required: go_led rises 8..20 cycles after busy rises; value=7 in DONE; go_led=0; value stable for 100 cycles.
- False start:
  - Stimulus: press, then press again 5 cycles after busy rises.
  - Required: ERROR with show_error=1, value=0, go_led=0.
  - A further press -> IDLE, show_error=0.
- Timeout:
  - Stimulus: MAX_MS=12, enter GO, never press.
  - Required: value counts 0..12 every 4 cycles, stops at 12; DONE; go_led=0.
- Held button and simultaneous events:
  - btn held high 200 cycles -> exactly one press.
  - Press aligned with delay expiry -> ERROR, not GO.
  - Press aligned with a GO tick -> value not incremented.
- Reset mid-GO at value=3 -> immediately value=0, go_led=0, busy=0; next press starts a fresh WAIT.
